// File: rtl/std_fp_mult_iter_pkg.sv
// Shared types for the iterative fixed-point multiplier.
// Holds the controller state encoding used by the datapath top.
package std_fp_mult_iter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/std_fp_mult_iter_mult.sv
// 8-bit integer wrapper around the iterative multiplier for the evaluation harness.
// Mirrors the 8-bit divider wrapper: no done output is exposed.
module mult (
  input  logic       go,
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] left,
  input  logic [7:0] right,
  output logic [7:0] out
);

  std_fp_mult_iter #(
    .WIDTH     (8),
    .INT_WIDTH (8),
    .FRAC_WIDTH(0)
  ) u_core (
    .clk  (clk),
    .reset(reset),
    .go   (go),
    .left (left),
    .right(right),
    .out  (out),
    .done ()
  );

endmodule

// File: rtl/std_fp_mult_iter.sv
// Iterative unsigned fixed-point shift-and-add multiplier, one partial product per cycle.
// go/done handshake; the result is truncated to the operand fixed-point format.
module std_fp_mult_iter
  import std_fp_mult_iter_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int INT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out,
  output logic             done
);

  localparam int IDX_W = $clog2(WIDTH) + 1;

  if (INT_WIDTH + FRAC_WIDTH != WIDTH) begin : g_bad_format
    $error("std_fp_mult_iter: INT_WIDTH + FRAC_WIDTH must equal WIDTH");
  end

  state_t           state, state_next;
  logic [IDX_W-1:0] idx, idx_next;
  logic [WIDTH-1:0] mcand, mcand_next;
  logic [WIDTH:0]   acc, acc_next;
  logic [WIDTH-1:0] low, low_next;
  logic [WIDTH-1:0] out_next;
  logic             done_next;

  logic             running;
  logic             finished;
  logic [WIDTH:0]   acc_sum;
  logic [2*WIDTH:0] stepped;

  assign running  = (state == BUSY);
  assign finished = running && (idx == IDX_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      mcand <= '0;
      acc   <= '0;
      low   <= '0;
      out   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      mcand <= mcand_next;
      acc   <= acc_next;
      low   <= low_next;
      out   <= out_next;
      done  <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    mcand_next = mcand;
    acc_next   = acc;
    low_next   = low;
    out_next   = out;
    done_next  = 1'b0;

    // Carry out of the add lands in acc[WIDTH] and is shifted down with the rest.
    acc_sum = low[0] ? (acc + {1'b0, mcand}) : acc;
    stepped = {acc_sum, low} >> 1;

    unique case (state)
      IDLE: begin
        if (go) begin
          if (left == '0 || right == '0) begin
            out_next  = '0;
            done_next = 1'b1;
          end else begin
            mcand_next = left;
            low_next   = right;
            acc_next   = '0;
            idx_next   = '0;
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        {acc_next, low_next} = stepped;
        idx_next             = idx + IDX_W'(1);
        if (finished) begin
          out_next   = stepped[WIDTH+FRAC_WIDTH-1:FRAC_WIDTH];
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
